// File: rtl/mode13h_pixel_pipeline.sv
// Mode 13h pixel pipeline: 320x200 framebuffer fetch with 2x doubling, 18-bit palette, 3-clock aligned syncs.
// Define MODE13H_BORDER_EN to paint the overscan border (visible but outside the image) with palette[0].
module mode13h_pixel_pipeline #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int H_LAST     = 799,
  parameter int V_OFFSET   = 40,
  parameter int FB_WIDTH   = 320,
  parameter int FB_LATENCY = 1
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [9:0]  i_h_count,
  input  logic [9:0]  i_v_count,
  input  logic        i_display_enable,
  input  logic        i_hsync_in,
  input  logic        i_vsync_in,
  output logic [15:0] o_fb_addr,
  output logic        o_fb_rd_en,
  input  logic [7:0]  i_fb_data,
  input  logic        i_pal_wr_en,
  input  logic [7:0]  i_pal_wr_idx,
  input  logic [17:0] i_pal_wr_data,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_hsync_out,
  output logic        o_vsync_out
);

  localparam logic [9:0]  HVis   = 10'(H_VISIBLE);
  localparam logic [9:0]  VVis   = 10'(V_VISIBLE);
  localparam logic [9:0]  HLast  = 10'(H_LAST);
  localparam logic [9:0]  VOff   = 10'(V_OFFSET);
  localparam logic [9:0]  VEnd   = 10'(V_OFFSET + 400);
  localparam logic [15:0] FbWide = 16'(FB_WIDTH);

  generate
    if (FB_LATENCY != 1) begin : g_bad_latency
      $error("mode13h_pixel_pipeline supports FB_LATENCY = 1 only");
    end
  endgenerate

  logic [15:0] r_row_base;
  logic        r_de_s1, r_vis_s1, r_de_s2, r_vis_s2;
  logic [2:0]  r_hsync_dly, r_vsync_dly;
  logic [17:0] r_palette [256];
  logic        w_in_image, w_visible, w_line_end, w_pal_on;
  logic [7:0]  w_pal_idx;

  assign w_in_image = (i_v_count >= VOff) && (i_v_count < VEnd);
  assign w_visible  = (i_h_count < HVis) && (i_v_count < VVis);
  assign w_line_end = (i_h_count == HLast);

  // Base advances after each odd image line so every framebuffer row is shown twice.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_row_base <= 16'd0;
    end else if (i_v_count < VOff) begin
      r_row_base <= 16'd0;
    end else if (w_line_end && w_in_image && i_v_count[0]) begin
      r_row_base <= r_row_base + FbWide;
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      o_fb_addr   <= 16'd0;
      o_fb_rd_en  <= 1'b0;
      r_de_s1     <= 1'b0;
      r_vis_s1    <= 1'b0;
      r_de_s2     <= 1'b0;
      r_vis_s2    <= 1'b0;
      r_hsync_dly <= 3'b111;
      r_vsync_dly <= 3'b111;
    end else begin
      o_fb_addr   <= r_row_base + {7'd0, i_h_count[9:1]};
      o_fb_rd_en  <= i_display_enable;
      r_de_s1     <= i_display_enable;
      r_vis_s1    <= w_visible;
      r_de_s2     <= r_de_s1;
      r_vis_s2    <= r_vis_s1;
      r_hsync_dly <= {r_hsync_dly[1:0], i_hsync_in};
      r_vsync_dly <= {r_vsync_dly[1:0], i_vsync_in};
    end
  end

  assign o_hsync_out = r_hsync_dly[2];
  assign o_vsync_out = r_vsync_dly[2];

  // Palette RAM has no reset; a same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk_25mhz) begin
    if (i_pal_wr_en) begin
      r_palette[i_pal_wr_idx] <= i_pal_wr_data;
    end
  end

`ifdef MODE13H_BORDER_EN
  assign w_pal_on  = r_de_s2 || r_vis_s2;
  assign w_pal_idx = r_de_s2 ? i_fb_data : 8'd0;
`else
  assign w_pal_on  = r_de_s2 && r_vis_s2;
  assign w_pal_idx = i_fb_data;
`endif

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      o_vga_r <= 4'd0;
      o_vga_g <= 4'd0;
      o_vga_b <= 4'd0;
    end else if (w_pal_on) begin
      o_vga_r <= r_palette[w_pal_idx][17:14];
      o_vga_g <= r_palette[w_pal_idx][11:8];
      o_vga_b <= r_palette[w_pal_idx][5:2];
    end else begin
      o_vga_r <= 4'd0;
      o_vga_g <= 4'd0;
      o_vga_b <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mode13h_pixel_pipeline.sv
// Directed bench for mode13h_pixel_pipeline: stub timing generator, framebuffer returning addr[7:0],
// palette[i] = {i[5:0],i[5:0],i[5:0]}. Border expectations follow MODE13H_BORDER_EN.
module tb_mode13h_pixel_pipeline;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic [9:0]  hCount, vCount;
  logic        displayEnable, hsyncIn, vsyncIn;
  logic [15:0] fbAddr;
  logic        fbRdEn;
  logic [7:0]  fbData = 8'd0;
  logic        palWrEn;
  logic [7:0]  palWrIdx;
  logic [17:0] palWrData;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic        hsyncOut, vsyncOut;

  int checkCount = 0;
  int failCount  = 0;

  logic [15:0] addrLog [800];
  logic        rdLog   [800];
  logic [11:0] rgbLog  [800];
  logic        hsLog   [800];

  always #20 clk_25mhz = ~clk_25mhz;

  // Framebuffer with one cycle of read latency whose content is the low address byte.
  always @(posedge clk_25mhz) begin
    if (fbRdEn) fbData <= fbAddr[7:0];
  end

  mode13h_pixel_pipeline dut (
    .clk_25mhz       (clk_25mhz),
    .reset           (reset),
    .i_h_count       (hCount),
    .i_v_count       (vCount),
    .i_display_enable(displayEnable),
    .i_hsync_in      (hsyncIn),
    .i_vsync_in      (vsyncIn),
    .o_fb_addr       (fbAddr),
    .o_fb_rd_en      (fbRdEn),
    .i_fb_data       (fbData),
    .i_pal_wr_en     (palWrEn),
    .i_pal_wr_idx    (palWrIdx),
    .i_pal_wr_data   (palWrData),
    .o_vga_r         (vgaR),
    .o_vga_g         (vgaG),
    .o_vga_b         (vgaB),
    .o_hsync_out     (hsyncOut),
    .o_vsync_out     (vsyncOut)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Stand-in for the VGA timing generator at a given raster position.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
    hCount        = h;
    vCount        = v;
    displayEnable = (h < 10'd640) && (v >= 10'd40) && (v < 10'd440);
    hsyncIn       = !((h >= 10'd656) && (h < 10'd752));
    vsyncIn       = !((v >= 10'd490) && (v < 10'd492));
  endtask

  // A line reduced to its final pixel: enough to advance the row base.
  task automatic jumpLine(input int v);
    @(negedge clk_25mhz);
    palWrEn = 1'b0;
    applyStimulus(10'd799, 10'(v));
  endtask

  // Full line; logs the stage-1 outputs per h and the 3-clock outputs per h.
  task automatic runLine(input int v, input int wrAtH);
    for (int h = 0; h < 800; h++) begin
      @(negedge clk_25mhz);
      if (h >= 1) begin
        addrLog[h-1] = fbAddr;
        rdLog[h-1]   = fbRdEn;
      end
      if (h >= 3) begin
        rgbLog[h-3] = {vgaR, vgaG, vgaB};
        hsLog[h-3]  = hsyncOut;
      end
      palWrEn   = (h == wrAtH);
      palWrIdx  = 8'd7;
      palWrData = 18'h3FFFF;
      applyStimulus(10'(h), 10'(v));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Addr"}, 32'(fbAddr), 32'd0);
    checkOutput({tag, "RdEn"}, 32'(fbRdEn), 32'd0);
    checkOutput({tag, "Rgb"}, 32'({vgaR, vgaG, vgaB}), 32'd0);
    checkOutput({tag, "Hsync"}, 32'(hsyncOut), 32'd1);
    checkOutput({tag, "Vsync"}, 32'(vsyncOut), 32'd1);
  endtask

  initial begin
    logic [5:0] low6;
    reset     = 1'b1;
    palWrEn   = 1'b0;
    palWrIdx  = 8'd0;
    palWrData = 18'd0;
    applyStimulus(10'd799, 10'd0);
    repeat (3) @(negedge clk_25mhz);
    checkResetValues("initReset");
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk_25mhz);
      low6      = 6'(i);
      palWrEn   = 1'b1;
      palWrIdx  = 8'(i);
      palWrData = {low6, low6, low6};
    end
    @(negedge clk_25mhz);
    palWrEn = 1'b0;

    // Mid-line traffic, then an asynchronous reset between clock edges.
    for (int h = 0; h <= 20; h++) begin
      @(negedge clk_25mhz);
      applyStimulus(10'(h), 10'd50);
    end
    @(negedge clk_25mhz);
    checkOutput("preResetAddr", 32'(fbAddr), 32'd10);
    checkOutput("preResetRgb", 32'({vgaR, vgaG, vgaB}), 32'h222);
    #5 reset = 1'b1;
    #1 checkResetValues("asyncReset");
    @(negedge clk_25mhz);
    reset = 1'b0;

    // New frame: palette[0] set for the border test during vertical top lines.
    @(negedge clk_25mhz);
    palWrEn   = 1'b1;
    palWrIdx  = 8'd0;
    palWrData = {6'h20, 6'h00, 6'h00};
    applyStimulus(10'd799, 10'd0);
    for (int v = 1; v < 10; v++) jumpLine(v);

    runLine(10, -1);
`ifdef MODE13H_BORDER_EN
    checkOutput("borderRgb", 32'(rgbLog[100]), 32'h800);
`else
    checkOutput("borderRgb", 32'(rgbLog[100]), 32'h000);
`endif
    checkOutput("blankRgb", 32'(rgbLog[700]), 32'h000);
    checkOutput("hsyncBeforeFall", 32'(hsLog[655]), 32'd1);
    checkOutput("hsyncFall", 32'(hsLog[656]), 32'd0);
    checkOutput("hsyncLastLow", 32'(hsLog[751]), 32'd0);
    checkOutput("hsyncRise", 32'(hsLog[752]), 32'd1);

    for (int v = 11; v < 40; v++) jumpLine(v);

    runLine(40, -1);
    checkOutput("line40Addr0", 32'(addrLog[0]), 32'd0);
    checkOutput("line40Addr639", 32'(addrLog[639]), 32'd319);
    checkOutput("line40RdFirst", 32'(rdLog[0]), 32'd1);
    checkOutput("line40RdLast", 32'(rdLog[639]), 32'd1);
    checkOutput("line40RdOff", 32'(rdLog[640]), 32'd0);

    runLine(41, -1);
    checkOutput("line41Addr0", 32'(addrLog[0]), 32'd0);
    checkOutput("line41Addr639", 32'(addrLog[639]), 32'd319);

    runLine(42, -1);
    checkOutput("line42Addr5", 32'(addrLog[5]), 32'd322);
    checkOutput("line42Rgb5", 32'(rgbLog[5]), 32'h000);
    checkOutput("line42Rgb7", 32'(rgbLog[7]), 32'h000);
    checkOutput("line42Rgb8", 32'(rgbLog[8]), 32'h111);
    checkOutput("line42Rgb100", 32'(rgbLog[100]), 32'hCCC);

    // Write palette[7] on the edge where stage 3 reads index 7 for h=398.
    runLine(43, 400);
    checkOutput("line43Addr0", 32'(addrLog[0]), 32'd320);
    checkOutput("palOldColour", 32'(rgbLog[398]), 32'h111);
    checkOutput("palNewColour", 32'(rgbLog[399]), 32'hFFF);

    for (int v = 44; v < 439; v++) jumpLine(v);

    runLine(439, -1);
    checkOutput("line439Addr0", 32'(addrLog[0]), 32'd63680);
    checkOutput("line439Addr639", 32'(addrLog[639]), 32'd63999);

    runLine(440, -1);
    checkOutput("line440RdEn", 32'(rdLog[100]), 32'd0);

    for (int v = 441; v < 490; v++) jumpLine(v);
    @(negedge clk_25mhz);
    applyStimulus(10'd0, 10'd490);
    @(negedge clk_25mhz);
    applyStimulus(10'd1, 10'd490);
    @(negedge clk_25mhz);
    checkOutput("vsyncStillHigh", 32'(vsyncOut), 32'd1);
    applyStimulus(10'd2, 10'd490);
    @(negedge clk_25mhz);
    checkOutput("vsyncFall", 32'(vsyncOut), 32'd0);
    applyStimulus(10'd3, 10'd490);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mode13h_pixel_pipeline.md
# mode13h_pixel_pipeline

Downstream stage of the VGA timing generator. It consumes the timing generator's `h_count`, `v_count`, `display_enable`, `hsync` and `vsync`, and fetches 8-bit Mode 13h pixels from the 320x200 framebuffer with 2x horizontal and vertical doubling. Each pixel index goes through a 256-entry 18-bit palette (VGA DAC style), and the block drives 4-bit-per-channel RGB with syncs delayed to stay pixel-aligned.

## Interface
- `H_VISIBLE`, 640: visible pixels per line.
- `V_VISIBLE`, 480: visible lines per frame.
- `H_LAST`, 799: final `h_count` value of a line.
- `V_OFFSET`, 40: first line of the doubled 640x400 image.
- `FB_WIDTH`, 320: logical pixels per framebuffer row.
- `FB_LATENCY`, 1: framebuffer read latency in cycles; only 1 is supported.
- `clk_25mhz` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `h_count` in 10: horizontal position from the timing generator.
- `v_count` in 10: vertical position from the timing generator.
- `display_enable` in 1: high inside the 640x400 logical window.
- `hsync_in`, `vsync_in` in 1 each: active-low syncs from the timing generator.
- `fb_addr` out 16: framebuffer byte address.
- `fb_rd_en` out 1: framebuffer read strobe.
- `fb_data` in 8: palette index returned 1 cycle after `fb_rd_en`.
- `pal_wr_en` in 1: palette write strobe.
- `pal_wr_idx` in 8: palette entry to write.
- `pal_wr_data` in 18: palette entry value, {R6,G6,B6}.
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour outputs.
- `hsync_out`, `vsync_out` out 1 each: delayed syncs.

## Operation
- Address generation:
  - `row_base` (16 bit) is cleared while `v_count < V_OFFSET`.
  - When `h_count == H_LAST`, `V_OFFSET <= v_count < V_OFFSET+400` and `v_count[0] == 1`, `row_base += FB_WIDTH`. Each framebuffer row is therefore used for two lines.
- Stage 1 (registered):
  - `fb_addr <= row_base + h_count[9:1]`.
  - `fb_rd_en <= display_enable`.
  - `display_enable` is delayed into `de_s1`.
  - The visible flag (`h_count < H_VISIBLE && v_count < V_VISIBLE`) is delayed into `vis_s1`.
- Stage 2: `fb_data` is valid. `de_s1` and `vis_s1` are registered into `de_s2` and `vis_s2`.
- Stage 3 (registered palette read):
  - If `de_s2`: RGB = bits [5:2] of each channel of `palette[fb_data]`.
  - Otherwise: RGB = border colour (see Configuration).
- Address range:
  - Maximum `fb_addr` is 63999.
  - `fb_addr` is don't-care when `fb_rd_en` is 0, but it is still registered.
- Palette:
  - 256 x 18 array, not reset; the contents are undefined until written.
  - A write takes effect on the clock edge where `pal_wr_en` is high.
  - A stage-3 read of the same index in the same cycle returns the old value (read-before-write).
  - Writes are accepted at any time, including during active video.
- Sync path: `hsync_in` and `vsync_in` pass through a 3-deep shift register to `hsync_out` and `vsync_out`.
- Reset mid-frame:
  - All pipeline registers and `row_base` clear.
  - Output is correct from the next frame start (`v_count < V_OFFSET`). Garbage addressing in the remainder of a partial frame is acceptable.

## Timing
- Reset values:
  - `fb_addr` = 0, `fb_rd_en` = 0.
  - `vga_r`, `vga_g`, `vga_b` = 0.
  - `hsync_out` = 1, `vsync_out` = 1.
  - Delay registers: syncs = 1, enables = 0.
- Latency: exactly 3 clocks from `h_count`/`v_count`/syncs to the matching RGB and sync outputs.
- `fb_rd_en` is asserted 1 cycle after `display_enable` and sustained for all 640 pixels of each logical line. The framebuffer must not stall; there is no backpressure.
- `row_base` increments on the same edge on which `h_count` wraps. The first pixel of the next line therefore uses the new base with no bubble.

## Configuration
- `MODE13H_BORDER_EN`:
  - When defined, a pixel with `vis_s2 && !de_s2` outputs `palette[0]` (overscan border, top/bottom 40 lines).
  - When undefined, every non-logical pixel outputs 0.
  - Blanking intervals (`!vis_s2`) always output 0.

## Test plan
- Reset asserted mid-line -> all outputs take their reset values asynchronously; after release and 1 frame, `fb_addr` at (`h_count`=0, `v_count`=40) is 0.
- Framebuffer model returning `addr[7:0]`, palette[i] = {i[5:0],i[5:0],i[5:0]} -> at `v_count`=42, `h_count`=5, `fb_addr` = 322; RGB 3 clocks later = 0x0 for index 0x42 (bits [5:2] of 0x02).
- Line doubling: `v_count` 40 and 41 both yield `fb_addr` 0..319; `v_count` 439 at `h_count`=639 yields `fb_addr` 63999; `fb_rd_en` is 0 at `v_count`=440.
- Palette write to index 7 with 0x3FFFF on the same cycle stage 3 reads index 7 -> that pixel shows the old colour; the next pixel with index 7 shows RGB 0xF/0xF/0xF.
- With `MODE13H_BORDER_EN` and palette[0] = {6'h20,0,0} -> `v_count`=10, `h_count`=100 gives R=0x8, G=0, B=0; `h_count`=700 gives 0. Without the macro, both give 0.
- Sync alignment: `hsync_in` falls at `h_count`=656 -> `hsync_out` falls 3 clocks later; `vsync_out` tracks `vsync_in` with the same 3-clock delay.
